// File: rtl/tinyqv_peri_pkg.sv
// Shared definitions for the TinyQV peripheral bus initiator and its load-extension helper.
package tinyqv_peri_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] IDLE_N    = 2'b11;

  localparam int PERI_WINDOW_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } bus_state_e;

endpackage

// File: rtl/tinyqv_load_extend.sv
// Extracts the low byte/halfword of a load and zero- or sign-extends it to 32 bits.
module tinyqv_load_extend
  import tinyqv_peri_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic byte_sign;
  logic half_sign;

  assign byte_sign = is_signed & data[7];
  assign half_sign = is_signed & data[15];

  always_comb begin
    result = data;
    case (size)
      SIZE_BYTE: result = {{24{byte_sign}}, data[7:0]};
      SIZE_HALF: result = {{16{half_sign}}, data[15:0]};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/tinyqv_peri_bus_master.sv
// Single-outstanding initiator for the TinyQV peripheral bus with request checking,
// load extension and a watchdog that aborts accesses the peripheral never acknowledges.
module tinyqv_peri_bus_master
  import tinyqv_peri_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [27:0] PERI_BASE      = 28'h800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [27:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [10:0] peri_addr,
  output logic [31:0] peri_wdata,
  output logic [1:0]  peri_write_n,
  output logic [1:0]  peri_read_n,
  input  logic [31:0] peri_rdata,
  input  logic        peri_data_ready,
  output logic        peri_read_complete
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       size_reg, size_next;
  logic             signed_reg, signed_next;

  logic [10:0] peri_addr_next;
  logic [31:0] peri_wdata_next;
  logic [1:0]  peri_write_n_next;
  logic [1:0]  peri_read_n_next;
  logic        peri_read_complete_next;
  logic        rsp_valid_next;
  logic        rsp_err_next;
  logic [31:0] rsp_rdata_next;

  logic        req_bad;
  logic [31:0] ext_data;

  tinyqv_load_extend u_extend (
    .data      (peri_rdata),
    .size      (size_reg),
    .is_signed (signed_reg),
    .result    (ext_data)
  );

  // Rejected requests never reach the peripheral bus.
  assign req_bad = (req_size == IDLE_N)
                || (req_size == SIZE_HALF && req_addr[0])
                || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                || (req_addr[27:PERI_WINDOW_BITS] != PERI_BASE[27:PERI_WINDOW_BITS]);

  assign req_ready = (state_reg == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      cnt_reg            <= '0;
      size_reg           <= SIZE_BYTE;
      signed_reg         <= 1'b0;
      peri_addr          <= '0;
      peri_wdata         <= '0;
      peri_write_n       <= IDLE_N;
      peri_read_n        <= IDLE_N;
      peri_read_complete <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_err            <= 1'b0;
      rsp_rdata          <= '0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      size_reg           <= size_next;
      signed_reg         <= signed_next;
      peri_addr          <= peri_addr_next;
      peri_wdata         <= peri_wdata_next;
      peri_write_n       <= peri_write_n_next;
      peri_read_n        <= peri_read_n_next;
      peri_read_complete <= peri_read_complete_next;
      rsp_valid          <= rsp_valid_next;
      rsp_err            <= rsp_err_next;
      rsp_rdata          <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next              = state_reg;
    cnt_next                = cnt_reg;
    size_next               = size_reg;
    signed_next             = signed_reg;
    peri_addr_next          = peri_addr;
    peri_wdata_next         = peri_wdata;
    peri_write_n_next       = peri_write_n;
    peri_read_n_next        = peri_read_n;
    peri_read_complete_next = 1'b0;
    rsp_valid_next          = 1'b0;
    rsp_err_next            = 1'b0;
    rsp_rdata_next          = '0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else begin
            peri_addr_next  = req_addr[PERI_WINDOW_BITS-1:0];
            peri_wdata_next = req_wdata;
            size_next       = req_size;
            signed_next     = req_signed;
            cnt_next        = '0;
            if (req_write) begin
              peri_write_n_next = req_size;
              state_next        = ST_WR;
            end else begin
              peri_read_n_next = req_size;
              state_next       = ST_RD;
            end
          end
        end
      end

      ST_WR: begin
        // Ready is checked before the expiry so a late ack still completes normally.
        if (peri_data_ready || cnt_reg == CNT_LAST) begin
          peri_write_n_next = IDLE_N;
          rsp_valid_next    = 1'b1;
          rsp_err_next      = !peri_data_ready;
          state_next        = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RD: begin
        // Read-complete is pulsed on abort too, releasing the wrapper's held read.
        if (peri_data_ready || cnt_reg == CNT_LAST) begin
          peri_read_n_next        = IDLE_N;
          peri_read_complete_next = 1'b1;
          rsp_valid_next          = 1'b1;
          rsp_err_next            = !peri_data_ready;
          rsp_rdata_next          = peri_data_ready ? ext_data : 32'h0;
          state_next              = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tinyqv_peri_bus_master.sv
// Randomised and directed checks of the peripheral bus initiator against a transaction-level model.
module tb_tinyqv_peri_bus_master;

  localparam int          TO   = 8;
  localparam logic [27:0] BASE = 28'h800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [27:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [10:0] peri_addr;
  logic [31:0] peri_wdata;
  logic [1:0]  peri_write_n;
  logic [1:0]  peri_read_n;
  logic [31:0] peri_rdata = '0;
  logic        peri_data_ready = 1'b0;
  logic        peri_read_complete;

  int checks = 0;
  int errors = 0;

  tinyqv_peri_bus_master #(.TIMEOUT_CYCLES(TO), .PERI_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .peri_addr(peri_addr), .peri_wdata(peri_wdata), .peri_write_n(peri_write_n),
    .peri_read_n(peri_read_n), .peri_rdata(peri_rdata), .peri_data_ready(peri_data_ready),
    .peri_read_complete(peri_read_complete)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transaction-level expectation: d is the number of active bus cycles before ready (-1 = never).
  function automatic void model(input logic [27:0] a, input bit wr, input logic [1:0] sz, input bit sg,
                                input int d, input logic [31:0] rd, output bit e, output logic [31:0] r,
                                output int lat, output int bus, output int rc);
    bit bad, tout;
    int nbits;
    longint v;
    bad  = (sz == 2'd3) || ((int'(a) % (1 << sz)) != 0) || ((a >> 11) != (BASE >> 11));
    tout = !bad && (d < 0 || d > TO - 1);
    e    = bad || tout;
    if (bad) begin lat = 1; bus = 0; rc = 0; end
    else if (tout) begin lat = TO + 1; bus = TO; rc = wr ? 0 : 1; end
    else begin lat = d + 2; bus = d + 1; rc = wr ? 0 : 1; end
    r = 32'h0;
    if (!e && !wr) begin
      if (sz == 2'd2) r = rd;
      else begin
        nbits = 8 << sz;
        v = longint'(rd) % (longint'(1) << nbits);
        if (sg && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
        r = v[31:0];
      end
    end
  endfunction

  // Issues one request from a negedge and plays the peripheral; returns what was observed.
  task automatic do_txn(input logic [27:0] a, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] wd, input int d, input logic [31:0] rd,
                        output bit seen, output bit o_err, output logic [31:0] o_rdata,
                        output int o_lat, output int o_bus, output int o_rc,
                        output logic [1:0] o_wn, output logic [1:0] o_rn,
                        output logic [10:0] o_addr, output logic [31:0] o_wdata);
    req_valid = 1'b1; req_addr = a; req_write = wr; req_size = sz; req_signed = sg; req_wdata = wd;
    peri_rdata = rd;
    step();
    req_valid = 1'b0;
    seen = 1'b0; o_err = 1'b0; o_rdata = '0; o_lat = 0; o_bus = 0; o_rc = 0;
    o_wn = 2'b11; o_rn = 2'b11; o_addr = '0; o_wdata = '0;
    for (int c = 1; c <= 40; c++) begin
      if (peri_write_n != 2'b11 || peri_read_n != 2'b11) begin
        if (o_bus == 0) begin
          o_wn = peri_write_n; o_rn = peri_read_n; o_addr = peri_addr; o_wdata = peri_wdata;
        end
        peri_data_ready = (d >= 0 && o_bus >= d);
        o_bus++;
      end else begin
        peri_data_ready = 1'b0;
      end
      if (peri_read_complete) o_rc++;
      if (rsp_valid && !seen) begin
        seen = 1'b1; o_lat = c; o_err = rsp_err; o_rdata = rsp_rdata;
      end
      if (seen && c > o_lat) break;
      step();
    end
    peri_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_addr = BASE; req_size = 2'b10;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if ({rsp_valid, rsp_err, peri_read_complete} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {rsp_valid, rsp_err, peri_read_complete}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    checks++; if ({peri_write_n, peri_read_n} !== 4'b1111) begin errors++;
      $display("FAIL reset_bus_n got %b exp 1111", {peri_write_n, peri_read_n}); end
    checks++; if ({peri_addr, peri_wdata} !== 43'h0) begin errors++;
      $display("FAIL reset_addr_wdata got %h/%h exp 0/0", peri_addr, peri_wdata); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  // Runs one transaction and compares every observed field with the model.
  task automatic run_checked(input string name, input logic [27:0] a, input bit wr, input logic [1:0] sz,
                             input bit sg, input logic [31:0] wd, input int d, input logic [31:0] rd);
    bit seen, oe, ee;
    logic [31:0] orr, er, owd;
    int ol, ob, orc, el, eb, erc;
    logic [1:0] own, orn;
    logic [10:0] oa;
    model(a, wr, sz, sg, d, rd, ee, er, el, eb, erc);
    do_txn(a, wr, sz, sg, wd, d, rd, seen, oe, orr, ol, ob, orc, own, orn, oa, owd);
    $display("%s addr=%h wr=%0d size=%0d sgn=%0d delay=%0d -> err=%0d rdata=%h lat=%0d",
             name, a, wr, sz, sg, d, oe, orr, ol);
    checks++; if (!seen) begin errors++; $display("FAIL %s_rsp got none exp rsp_valid", name); end
    checks++; if (oe !== ee) begin errors++; $display("FAIL %s_err got %b exp %b", name, oe, ee); end
    checks++; if (orr !== er) begin errors++; $display("FAIL %s_rdata got %h exp %h", name, orr, er); end
    checks++; if (ol != el) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, ol, el); end
    checks++; if (ob != eb) begin errors++; $display("FAIL %s_bus_cycles got %0d exp %0d", name, ob, eb); end
    checks++; if (orc != erc) begin errors++; $display("FAIL %s_read_complete got %0d exp %0d", name, orc, erc); end
    if (eb > 0) begin
      checks++; if ({own, orn} !== (wr ? {sz, 2'b11} : {2'b11, sz})) begin errors++;
        $display("FAIL %s_strobes got %b/%b exp size %b on %s", name, own, orn, sz, wr ? "write" : "read"); end
      checks++; if (oa !== a[10:0]) begin errors++; $display("FAIL %s_peri_addr got %h exp %h", name, oa, a[10:0]); end
      if (wr) begin
        checks++; if (owd !== wd) begin errors++; $display("FAIL %s_peri_wdata got %h exp %h", name, owd, wd); end
      end
    end
    checks++; if ({peri_write_n, peri_read_n} !== 4'b1111) begin errors++;
      $display("FAIL %s_bus_idle_after got %b exp 1111", name, {peri_write_n, peri_read_n}); end
  endtask

  task automatic test_directed();
    run_checked("word_store",  28'h800_0040, 1'b1, 2'b10, 1'b0, 32'h0000_00A5, 0, 32'h0);
    run_checked("sbyte_load",  28'h800_0044, 1'b0, 2'b00, 1'b1, 32'h0, 1, 32'h0000_0080);
    run_checked("ubyte_load",  28'h800_0044, 1'b0, 2'b00, 1'b0, 32'h0, 1, 32'h0000_0080);
    run_checked("shalf_load",  28'h800_0102, 1'b0, 2'b01, 1'b1, 32'h0, 2, 32'h1234_8001);
    run_checked("half_misal",  28'h800_0101, 1'b0, 2'b01, 1'b0, 32'h0, 1, 32'hFFFF_FFFF);
    run_checked("out_of_win",  28'h800_0800, 1'b0, 2'b10, 1'b0, 32'h0, 1, 32'hFFFF_FFFF);
    run_checked("size_11",     28'h800_0010, 1'b1, 2'b11, 1'b0, 32'h1, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_checked("rd_timeout",   28'h800_0200, 1'b0, 2'b10, 1'b0, 32'h0, -1, 32'hDEAD_BEEF);
    run_checked("wr_timeout",   28'h800_0204, 1'b1, 2'b10, 1'b0, 32'h55, -1, 32'h0);
    run_checked("rd_ready_last", 28'h800_0208, 1'b0, 2'b10, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D);
    run_checked("rd_ready_late", 28'h800_020C, 1'b0, 2'b10, 1'b0, 32'h0, TO, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_read();
    int extra_rsp = 0;
    req_valid = 1'b1; req_addr = 28'h800_0048; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    step();
    req_valid = 1'b0;
    checks++; if (peri_read_n !== 2'b10) begin errors++; $display("FAIL midrst_read_n got %b exp 10", peri_read_n); end
    step(); step();
    rst_n = 1'b0;
    step();
    checks++; if ({peri_read_n, rsp_valid, peri_read_complete} !== 4'b1100) begin errors++;
      $display("FAIL midrst_bus got %b exp 1100", {peri_read_n, rsp_valid, peri_read_complete}); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || peri_read_complete) extra_rsp++;
      step();
    end
    checks++; if (extra_rsp != 0) begin errors++; $display("FAIL midrst_stray_rsp got %0d exp 0", extra_rsp); end
    run_checked("after_rst", 28'h800_004C, 1'b0, 2'b01, 1'b1, 32'h0, 1, 32'h0000_F00F);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    req_valid = 1'b1; req_addr = 28'h800_0003; req_write = 1'b0; req_size = 2'b10;
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp got %b exp 0", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) pulses++;
      if (i < 5) step();
    end
    req_valid = 1'b0;
    step(); step();
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_rsp_count got %0d exp 3", pulses); end
  endtask

  task automatic test_random();
    logic [27:0] a;
    logic [1:0] sz;
    bit wr;
    int d;
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom);
      a  = BASE + 28'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) a = 28'($urandom);
      if ($urandom_range(0, 1) == 0) a = a & ~28'h3;
      if (wr) d = $urandom_range(0, 3);
      else    d = $urandom_range(1, TO + 1);
      if ($urandom_range(0, 9) == 0) d = -1;
      run_checked($sformatf("rnd%0d", n), a, wr, sz, 1'($urandom), $urandom, d, $urandom);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
